scroll_7_seg: RTL and testbench

Parametrised multi-digit seven-segment message driver for the board-level display path. It holds a programmable message of character codes, decodes them to active-low segment patterns, and drives `DIGITS` displays. Modes are static, scroll-left, scroll-right and blink, paced by an internal prescaler. It replaces fixed, hard-wired per-digit decoders at board top level.

---
 rtl/seg_pkg.sv | 21 ++
 rtl/scroll_7_seg_if.sv | 22 ++
 rtl/seg_char_decoder.sv | 26 ++
 rtl/scroll_7_seg.sv | 96 +++++++++
 tb/tb_scroll_7_seg.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the scrolling seven-segment message driver:
// character codes, display modes and the all-off segment pattern.
package seg_pkg;

    localparam logic [2:0] CH_BLANK = 3'd0;
    localparam logic [2:0] CH_H     = 3'd1;
    localparam logic [2:0] CH_E     = 3'd2;
    localparam logic [2:0] CH_L     = 3'd3;
    localparam logic [2:0] CH_O     = 3'd4;
    localparam logic [2:0] CH_D     = 3'd5;
    localparam logic [2:0] CH_ONE   = 3'd6;
    localparam logic [2:0] CH_DASH  = 3'd7;

    localparam logic [1:0] MODE_STATIC = 2'b00;
    localparam logic [1:0] MODE_LEFT   = 2'b01;
    localparam logic [1:0] MODE_RIGHT  = 2'b10;
    localparam logic [1:0] MODE_BLINK  = 2'b11;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/scroll_7_seg_if.sv
// Control, message-write and display signals of the scrolling driver.
// The master side drives controls and writes; the slave side is the driver.
interface scroll_7_seg_if #(
    parameter int DIGITS  = 4,
    parameter int MSG_LEN = 8
);
    localparam int AW = $clog2(MSG_LEN);

    logic                  en;
    logic [1:0]            mode;
    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [2:0]            wr_data;
    logic [7*DIGITS-1:0]   hex;
    logic                  step;
    logic [AW-1:0]         offset;

    modport master (output en, mode, wr_en, wr_addr, wr_data,
                    input  hex, step, offset);
    modport slave  (input  en, mode, wr_en, wr_addr, wr_data,
                    output hex, step, offset);
endinterface

// File: rtl/seg_char_decoder.sv
// Combinational character-code to active-low segment decoder.
// Output bit 0 is segment a, bit 6 is segment g.
module seg_char_decoder
    import seg_pkg::*;
(
    input  logic [2:0] code,
    output logic [6:0] seg
);

    // Literals are written g..a (MSB first), so they read reversed from a..g.
    always_comb begin
        // NOTE: default assignment first so every path drives seg; no latch.
        seg = SEG_BLANK;
        case (code)
            CH_H:     seg = 7'b0001001;
            CH_E:     seg = 7'b0000110;
            CH_L:     seg = 7'b1000111;
            CH_O:     seg = 7'b1000000;
            CH_D:     seg = 7'b0100001;
            CH_ONE:   seg = 7'b1111001;
            CH_DASH:  seg = 7'b0111111;
            default:  seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/scroll_7_seg.sv
// Multi-digit seven-segment message driver with static, scroll-left,
// scroll-right and blink modes paced by an internal prescaler.
module scroll_7_seg
    import seg_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int MSG_LEN  = 8,
    parameter int TICK_DIV = 25_000_000
) (
    input  logic           CLOCK_50,
    input  logic           reset,
    scroll_7_seg_if.slave  bus
);

    localparam int AW = $clog2(MSG_LEN);
    localparam int CW = $clog2(TICK_DIV);
    localparam logic [AW-1:0] OFF_LAST = AW'(MSG_LEN - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0]        cnt_q, cnt_d;
    logic [AW-1:0]        off_q, off_d;
    logic                 phase_q, phase_d;
    logic [1:0]           mode_q;
    logic [2:0]           msg_q [MSG_LEN];
    logic [7*DIGITS-1:0]  hex_q, hex_d;
    logic                 mode_chg;
    logic                 step;
    logic                 wr_ok;

    // A mode change restarts pacing, so that cycle can never be a step.
    assign mode_chg = (bus.mode != mode_q);
    assign step     = bus.en && !mode_chg && (cnt_q == CNT_LAST);
    assign wr_ok    = bus.wr_en && ({1'b0, bus.wr_addr} < (AW+1)'(MSG_LEN));

    always_comb begin
        cnt_d   = cnt_q;
        off_d   = off_q;
        phase_d = phase_q;
        if (mode_chg) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (bus.en) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end
        if (step && bus.mode == MODE_BLINK)
            phase_d = !phase_q;
        case (bus.mode)
            MODE_STATIC: off_d = '0;
            MODE_LEFT:   if (step) off_d = (off_q == OFF_LAST) ? '0 : off_q + 1'b1;
            MODE_RIGHT:  if (step) off_d = (off_q == '0) ? OFF_LAST : off_q - 1'b1;
            default:     off_d = off_q;
        endcase
    end

    // Leftmost digit (index DIGITS-1) shows the character at the offset.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        logic [AW-1:0] sel;
        logic [6:0]    seg;

        assign sel = AW'((int'(off_q) + DIGITS - 1 - gi) % MSG_LEN);

        seg_char_decoder u_dec (
            .code (msg_q[sel]),
            .seg  (seg)
        );

        assign hex_d[7*gi +: 7] = phase_q ? seg : SEG_BLANK;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            off_q   <= '0;
            phase_q <= 1'b1;
            mode_q  <= MODE_STATIC;
            hex_q   <= '1;
            // NOTE: the message buffer is small and must power up blank, so it is reset like any register.
            for (int i = 0; i < MSG_LEN; i++)
                msg_q[i] <= CH_BLANK;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            cnt_q   <= cnt_d;
            off_q   <= off_d;
            phase_q <= phase_d;
            mode_q  <= bus.mode;
            hex_q   <= hex_d;
            if (wr_ok)
                msg_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    assign bus.hex    = hex_q;
    assign bus.step   = step;
    assign bus.offset = off_q;

endmodule

// File: tb/tb_scroll_7_seg.sv
// Self-checking bench for scroll_7_seg (DIGITS=4, MSG_LEN=6, TICK_DIV=4).
// Expected values are queued as stimulus is applied and popped at sample time.
module tb_scroll_7_seg;
    import seg_pkg::*;

    localparam int DIGITS   = 4;
    localparam int MSG_LEN  = 6;
    localparam int TICK_DIV = 4;
    localparam logic [27:0] ALL_OFF = {28{1'b1}};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc_no = 0;

    logic [2:0]  msg [MSG_LEN];
    logic [27:0] hex_exp_q [$];
    int          off_exp_q [$];

    scroll_7_seg_if #(.DIGITS(DIGITS), .MSG_LEN(MSG_LEN)) bus ();

    scroll_7_seg #(.DIGITS(DIGITS), .MSG_LEN(MSG_LEN), .TICK_DIV(TICK_DIV)) dut (
        .CLOCK_50 (clk),
        .reset    (rst),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    // Glyph table written as a..g strings (a leftmost), then mapped to bit 0 = a.
    function automatic logic [6:0] glyph(input logic [2:0] c);
        logic [6:0] s;
        logic [6:0] r;
        case (c)
            3'd0: s = 7'b1111111;
            3'd1: s = 7'b1001000;
            3'd2: s = 7'b0110000;
            3'd3: s = 7'b1110001;
            3'd4: s = 7'b0000001;
            3'd5: s = 7'b1000010;
            3'd6: s = 7'b1001111;
            default: s = 7'b1111110;
        endcase
        for (int k = 0; k < 7; k++) r[k] = s[6-k];
        return r;
    endfunction

    function automatic logic [27:0] exp_hex(input int off, input bit ph);
        logic [27:0] r;
        for (int d = 0; d < DIGITS; d++)
            r[7*d +: 7] = ph ? glyph(msg[(off + DIGITS - 1 - d) % MSG_LEN]) : 7'h7f;
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #2;
        cyc_no++;
    endtask

    task automatic wait_step(output bit found);
        found = 1'b0;
        for (int i = 0; i < 16 && !found; i++) begin
            if (bus.step === 1'b1) found = 1'b1;
            else cyc();
        end
    endtask

    task automatic test_reset();
        bus.en = 1'b0; bus.mode = MODE_STATIC; bus.wr_en = 1'b0;
        bus.wr_addr = '0; bus.wr_data = '0;
        rst = 1'b1;
        repeat (3) cyc();
        vectors++;
        if (bus.hex !== ALL_OFF || bus.offset !== 3'd0 || bus.step !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: hex=%h off=%0d step=%b, want hex=%h off=0 step=0",
                     bus.hex, bus.offset, bus.step, ALL_OFF);
        end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_static_write();
        logic [2:0]  codes [MSG_LEN];
        logic [27:0] eh;
        int          eo;
        codes = '{CH_H, CH_E, CH_L, CH_L, CH_O, CH_BLANK};
        for (int a = 0; a < MSG_LEN; a++) begin
            bus.wr_en = 1'b1; bus.wr_addr = 3'(a); bus.wr_data = codes[a];
            msg[a] = codes[a];
            cyc();
        end
        bus.wr_en = 1'b0;
        bus.en = 1'b1;
        cyc();
        for (int i = 0; i < 8; i++) begin
            hex_exp_q.push_back({glyph(CH_H), glyph(CH_E), glyph(CH_L), glyph(CH_L)});
            off_exp_q.push_back(0);
        end
        for (int i = 0; i < 8; i++) begin
            eh = hex_exp_q.pop_front();
            eo = off_exp_q.pop_front();
            vectors++;
            if (bus.hex !== eh || bus.offset !== 3'(eo)) begin
                miscompares++;
                $display("FAIL static_hello[%0d]: hex=%h off=%0d, want hex=%h off=%0d",
                         i, bus.hex, bus.offset, eh, eo);
            end
            cyc();
        end
    endtask

    task automatic test_scroll(input logic [1:0] md, input int n);
        bit found;
        int last;
        int eo;
        bus.mode = md;
        last = -1;
        for (int s = 0; s < n; s++) begin
            wait_step(found);
            vectors++;
            if (!found) begin
                miscompares++;
                $display("FAIL scroll_step_timeout[%0d]: no step seen, want step", s);
            end
            if (last >= 0) begin
                vectors++;
                if (cyc_no - last != TICK_DIV) begin
                    miscompares++;
                    $display("FAIL step_spacing[%0d]: %0d cycles, want %0d", s, cyc_no - last, TICK_DIV);
                end
            end
            last = cyc_no;
            cyc();
            eo = off_exp_q.pop_front();
            vectors++;
            if (bus.offset !== 3'(eo)) begin
                miscompares++;
                $display("FAIL scroll_offset[%0d]: off=%0d, want %0d", s, bus.offset, eo);
            end
            if (eo == 4 && md == MODE_LEFT) begin
                cyc();
                vectors++;
                if (bus.hex !== {glyph(CH_O), glyph(CH_BLANK), glyph(CH_H), glyph(CH_E)}) begin
                    miscompares++;
                    $display("FAIL scroll_hex_off4: hex=%h, want %h", bus.hex,
                             {glyph(CH_O), glyph(CH_BLANK), glyph(CH_H), glyph(CH_E)});
                end
            end
        end
    endtask

    task automatic test_scroll_left_right();
        int nsteps;
        foreach (off_exp_q[i]) off_exp_q.delete(i);
        off_exp_q = {1, 2, 3, 4, 5, 0};
        test_scroll(MODE_LEFT, 6);
        off_exp_q = {5, 4};
        test_scroll(MODE_RIGHT, 2);
        bus.en = 1'b0;
        nsteps = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (bus.step !== 1'b0) nsteps++;
        end
        vectors++;
        if (nsteps != 0 || bus.offset !== 3'd4) begin
            miscompares++;
            $display("FAIL freeze: steps=%0d off=%0d, want steps=0 off=4", nsteps, bus.offset);
        end
        bus.en = 1'b1;
    endtask

    task automatic test_blink_and_mode_change();
        bit          found;
        logic [27:0] pat;
        logic [27:0] eh;
        bus.mode = MODE_BLINK;
        pat = exp_hex(4, 1'b1);
        wait_step(found);
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL blink_step_timeout: no step seen, want step");
        end
        hex_exp_q.push_back(pat);
        repeat (4) hex_exp_q.push_back(ALL_OFF);
        repeat (4) hex_exp_q.push_back(pat);
        for (int i = 1; i <= 9; i++) begin
            cyc();
            eh = hex_exp_q.pop_front();
            vectors++;
            if (bus.hex !== eh || bus.offset !== 3'd4) begin
                miscompares++;
                $display("FAIL blink[%0d]: hex=%h off=%0d, want hex=%h off=4",
                         i, bus.hex, bus.offset, eh);
            end
        end
        // Phase is off and the prescaler is mid-count here.
        cyc();
        bus.mode = MODE_STATIC;
        cyc();
        cyc();
        vectors++;
        if (bus.step !== 1'b0 || bus.hex !== exp_hex(0, 1'b1)) begin
            miscompares++;
            $display("FAIL mode_change_restart: step=%b hex=%h, want step=0 hex=%h",
                     bus.step, bus.hex, exp_hex(0, 1'b1));
        end
        cyc();
        cyc();
        vectors++;
        if (bus.step !== 1'b1) begin
            miscompares++;
            $display("FAIL restart_step: step=%b, want 1", bus.step);
        end
        bus.mode = MODE_LEFT;
        #1;
        vectors++;
        if (bus.step !== 1'b0) begin
            miscompares++;
            $display("FAIL mode_change_no_step: step=%b, want 0", bus.step);
        end
        cyc();
        vectors++;
        if (bus.offset !== 3'd0) begin
            miscompares++;
            $display("FAIL mode_change_offset: off=%0d, want 0", bus.offset);
        end
    endtask

    task automatic test_write_on_step();
        bit          found;
        logic [27:0] eh;
        wait_step(found);
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL wstep_timeout: no step seen, want step");
        end
        bus.wr_en = 1'b1; bus.wr_addr = 3'd1; bus.wr_data = CH_DASH;
        hex_exp_q.push_back(exp_hex(0, 1'b1));
        msg[1] = CH_DASH;
        hex_exp_q.push_back(exp_hex(1, 1'b1));
        cyc();
        bus.wr_en = 1'b0;
        eh = hex_exp_q.pop_front();
        vectors++;
        if (bus.offset !== 3'd1 || bus.hex !== eh) begin
            miscompares++;
            $display("FAIL wstep_edge: off=%0d hex=%h, want off=1 hex=%h", bus.offset, bus.hex, eh);
        end
        cyc();
        eh = hex_exp_q.pop_front();
        vectors++;
        if (bus.hex[27:21] !== 7'b0111111 || bus.hex !== eh) begin
            miscompares++;
            $display("FAIL wstep_glyph: hex=%h, want %h", bus.hex, eh);
        end
    endtask

    task automatic test_reset_mid_scroll();
        bit found;
        int rel;
        for (int s = 0; s < 2; s++) begin
            wait_step(found);
            cyc();
        end
        vectors++;
        if (bus.offset !== 3'd3) begin
            miscompares++;
            $display("FAIL pre_reset_offset: off=%0d, want 3", bus.offset);
        end
        cyc();
        rst = 1'b1;
        #1;
        vectors++;
        if (bus.hex !== ALL_OFF || bus.offset !== 3'd0 || bus.step !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: hex=%h off=%0d step=%b, want hex=%h off=0 step=0",
                     bus.hex, bus.offset, bus.step, ALL_OFF);
        end
        bus.mode = MODE_STATIC;
        for (int a = 0; a < MSG_LEN; a++) msg[a] = CH_BLANK;
        cyc();
        cyc();
        rst = 1'b0;
        rel = cyc_no;
        wait_step(found);
        vectors++;
        if (!found || cyc_no - rel != TICK_DIV - 1) begin
            miscompares++;
            $display("FAIL first_step_after_reset: found=%b edges=%0d, want found=1 edges=%0d",
                     found, cyc_no - rel, TICK_DIV - 1);
        end
        bus.en = 1'b0;
        bus.wr_en = 1'b1; bus.wr_addr = 3'd6; bus.wr_data = CH_E;
        cyc();
        bus.wr_addr = 3'd3; bus.wr_data = CH_H;
        cyc();
        bus.wr_en = 1'b0;
        cyc();
        vectors++;
        if (bus.hex !== {glyph(CH_BLANK), glyph(CH_BLANK), glyph(CH_BLANK), glyph(CH_H)}) begin
            miscompares++;
            $display("FAIL oob_write: hex=%h, want %h", bus.hex,
                     {glyph(CH_BLANK), glyph(CH_BLANK), glyph(CH_BLANK), glyph(CH_H)});
        end
    endtask

    initial begin
        for (int a = 0; a < MSG_LEN; a++) msg[a] = CH_BLANK;
        test_reset();
        test_static_write();
        test_scroll_left_right();
        test_blink_and_mode_change();
        test_write_on_step();
        test_reset_mid_scroll();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

endmodule
